// File: rtl/mem_access_unit_pkg.sv
// Shared load/store mode codes, state encodings and counter width for the MEM-stage access unit.
package mem_access_unit_pkg;

    localparam int L_S_MODE_W = 3;

    localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = 3'd0;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = 3'd1;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF   = 3'd2;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = 3'd3;
    localparam logic [L_S_MODE_W-1:0] L_S_WORD   = 3'd4;

    localparam int MAU_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUSY = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit_lane_format.sv
// Combinational lane formatting: alignment check, byte enables, store replication and load extension.
// Request side uses the live instruction; response side uses the mode/offset latched at request time.
module lsu_lane_format
    import mem_access_unit_pkg::*;
(
    input  logic [L_S_MODE_W-1:0] req_mode,
    input  logic [1:0]            req_off,
    input  logic [31:0]           store_data,
    output logic                  aligned,
    output logic [3:0]            be,
    output logic [31:0]           wdata,
    input  logic [L_S_MODE_W-1:0] rsp_mode,
    input  logic [1:0]            rsp_off,
    input  logic [31:0]           rdata,
    output logic [31:0]           ldata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        aligned = (req_off == 2'b00);
        be      = 4'b1111;
        wdata   = store_data;
        case (req_mode)
            L_S_BYTE, L_S_BYTE_U: begin
                aligned = 1'b1;
                be      = 4'b0001 << req_off;
                wdata   = {4{store_data[7:0]}};
            end
            L_S_HALF, L_S_HALF_U: begin
                aligned = ~req_off[0];
                be      = req_off[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (rsp_off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = rsp_off[1] ? rdata[31:16] : rdata[15:0];
        case (rsp_mode)
            L_S_BYTE:   ldata = {{24{lane_b[7]}}, lane_b};
            L_S_BYTE_U: ldata = {24'd0, lane_b};
            L_S_HALF:   ldata = {{16{lane_h[15]}}, lane_h};
            L_S_HALF_U: ldata = {16'd0, lane_h};
            default:    ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one single-beat req/ack bus transaction per aligned access,
// stalling the pipeline until ack or timeout; misaligned accesses are flagged and dropped.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  misalign,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack
);

    localparam logic [MAU_TIMEOUT_W-1:0] CNT_LAST = MAU_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    mau_state_e                state_q;
    logic [MAU_TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [L_S_MODE_W-1:0]     mode_q;
    logic [1:0]                off_q;
    logic                      req_q, we_q, misalign_q, err_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [3:0]                be_q;
    logic [31:0]               wdata_q, load_q;

    logic        access, aligned;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata, fmt_ldata;

    assign access = mem_read_en | mem_write_en;
    assign cnt_d  = cnt_q + 1'b1;

    lsu_lane_format u_fmt (
        .req_mode   (l_s_mode),
        .req_off    (addr[1:0]),
        .store_data (store_data),
        .aligned    (aligned),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .rsp_mode   (mode_q),
        .rsp_off    (off_q),
        .rdata      (bus_rdata),
        .ldata      (fmt_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MAU_IDLE;
            cnt_q      <= '0;
            mode_q     <= '0;
            off_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                MAU_IDLE: begin
                    if (access && !aligned) begin
                        misalign_q <= 1'b1;
                    end else if (access) begin
                        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        be_q    <= fmt_be;
                        wdata_q <= fmt_wdata;
                        we_q    <= ~mem_read_en;
                        mode_q  <= l_s_mode;
                        off_q   <= addr[1:0];
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= MAU_BUSY;
                    end
                end
                MAU_BUSY: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (bus_ack) begin
                        if (!we_q) load_q <= fmt_ldata;
                        req_q   <= 1'b0;
                        state_q <= MAU_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (!we_q) load_q <= '0;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= MAU_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= MAU_IDLE;
            endcase
        end
    end

    assign stall     = ~rst & ((state_q == MAU_BUSY) | ((state_q == MAU_IDLE) & access & aligned));
    assign load_data = load_q;
    assign misalign  = misalign_q;
    assign bus_err   = err_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load/store vectors checked through a bus-side scoreboard,
// plus hand-written misalign, timeout and reset-during-BUSY sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk, rst;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  l_s_mode;
    logic [31:0] addr, store_data;
    logic        stall, misalign, bus_err, bus_req, bus_we, bus_ack;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .l_s_mode(l_s_mode), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  mode;
        logic [31:0] addr, sdata, rdata;
        int          dly;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        logic [31:0] e_load;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mode,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdv,
                                input int dly, input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mode = mode; v.addr = a; v.sdata = sd; v.rdata = rdv;
        v.dly = dly; v.e_be = be; v.e_addr = {a[31:2], 2'b00}; v.e_wdata = wd;
        v.e_we = wr & ~rd; v.e_load = ld;
        return v;
    endfunction

    // Scoreboard: each completed bus beat must match the oldest issued request.
    always @(negedge clk) begin
        if (!rst && bus_req && bus_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("bus_be",    {28'd0, bus_be}, {28'd0, e.e_be});
                chk("bus_addr",  bus_addr,        e.e_addr);
                chk("bus_wdata", bus_wdata,       e.e_wdata);
                chk("bus_we",    {31'd0, bus_we}, {31'd0, e.e_we});
            end
        end
    end

    task automatic idle_inputs();
        mem_read_en = 1'b0; mem_write_en = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int stall_cnt;
        @(posedge clk); #1;
        mem_read_en = v.rd; mem_write_en = v.wr; l_s_mode = v.mode;
        addr = v.addr; store_data = v.sdata;
        exp_q.push_back(v);
        @(negedge clk);
        stall_cnt = stall ? 1 : 0;
        for (int k = 0; k <= v.dly; k++) begin
            @(posedge clk); #1;
            mem_read_en = 1'b0; mem_write_en = 1'b0;
            bus_rdata = v.rdata;
            bus_ack = (k == v.dly);
            @(negedge clk);
            if (stall) stall_cnt++;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        bus_rdata = 32'hDEAD_0000;
        @(negedge clk);
        chk({tag, "_stall_cycles"}, stall_cnt, 2 + v.dly);
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_load_data"}, load_data, v.e_load);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; l_s_mode = L_S_WORD; addr = '0; store_data = '0; bus_rdata = '0;
        idle_inputs();

        vecs[0] = mk(1, 0, L_S_BYTE,   32'h1003, 32'h0,         32'h80FF_1234, 1, 4'b1000, 32'h0,         32'hFFFF_FF80);
        vecs[1] = mk(0, 1, L_S_HALF,   32'h2002, 32'h0000_ABCD, 32'h1111_1111, 0, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
        vecs[2] = mk(1, 0, L_S_HALF_U, 32'h4002, 32'h0,         32'h9876_0000, 0, 4'b1100, 32'h0,         32'h0000_9876);
        vecs[3] = mk(1, 0, L_S_HALF,   32'h4002, 32'h0,         32'h9876_0000, 2, 4'b1100, 32'h0,         32'hFFFF_9876);
        vecs[4] = mk(0, 1, L_S_BYTE,   32'h5001, 32'h1234_56A5, 32'h2222_2222, 0, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_9876);
        vecs[5] = mk(1, 0, L_S_BYTE_U, 32'h6002, 32'h0,         32'h11C3_2233, 1, 4'b0100, 32'h0,         32'h0000_00C3);
        vecs[6] = mk(0, 1, L_S_WORD,   32'h7004, 32'hDEAD_BEEF, 32'h3333_3333, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_00C3);
        vecs[7] = mk(1, 0, L_S_WORD,   32'h8008, 32'h0,         32'hCAFE_F00D, 3, 4'b1111, 32'h0,         32'hCAFE_F00D);
        vecs[8] = mk(1, 0, L_S_HALF,   32'h9000, 32'h0,         32'h1234_8001, 0, 4'b0011, 32'h0,         32'hFFFF_8001);
        vecs[9] = mk(1, 1, L_S_WORD,   32'hA000, 32'h5555_5555, 32'h0BAD_F00D, 1, 4'b1111, 32'h5555_5555, 32'h0BAD_F00D);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_load",  load_data, 32'd0);
        chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Misaligned word then half: flagged one cycle later, no bus activity.
        for (int m = 0; m < 2; m++) begin
            @(posedge clk); #1;
            mem_read_en = 1'b1;
            l_s_mode = (m == 0) ? L_S_WORD : L_S_HALF_U;
            addr = (m == 0) ? 32'h3002 : 32'h3001;
            @(negedge clk);
            chk("mis_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1; idle_inputs();
            @(negedge clk);
            chk("mis_pulse", {31'd0, misalign}, 32'd1);
            chk("mis_req",   {31'd0, bus_req}, 32'd0);
            chk("mis_load",  load_data, 32'h0BAD_F00D);
            @(posedge clk); #1;
            @(negedge clk);
            chk("mis_clear", {31'd0, misalign}, 32'd0);
        end

        // Timeout: no ack, four BUSY cycles, then bus_err in DONE.
        @(posedge clk); #1;
        mem_read_en = 1'b1; l_s_mode = L_S_WORD; addr = 32'hB000;
        @(posedge clk); #1; idle_inputs();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_req) n++;
            else break;
            @(posedge clk); #1;
        end
        chk("to_busy_cycles", n, 4);
        chk("to_err",   {31'd0, bus_err}, 32'd1);
        chk("to_load",  load_data, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("to_err_clear", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1; bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_req",   {31'd0, bus_req}, 32'd0);
        chk("stray_load",  load_data, 32'd0);
        chk("stray_stall", {31'd0, stall}, 32'd0);

        // Reset while BUSY drops the request immediately.
        @(posedge clk); #1;
        mem_read_en = 1'b1; l_s_mode = L_S_WORD; addr = 32'hC000;
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req",   {31'd0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, bus_req, stall}, 32'd0);

        run_vec(mk(1, 0, L_S_BYTE, 32'hD001, 32'h0, 32'h0000_7F00, 0, 4'b0010, 32'h0, 32'h0000_007F), "after_rst");

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
